// File: rtl/tt_um_sofiaeg_sum_tx.sv
// rtl/tt_um_sofiaeg_sum_tx.sv - operand burst accumulator with two-byte valid/ack transmit
module tt_um_sofiaeg_sum_tx #(
  parameter int N_OPERANDS = 2,
  parameter int SUM_W      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena
);
  typedef enum logic [1:0] {IDLE, ACCUM, SEND_LO, SEND_HI} state_t;

  localparam logic [7:0] LAST_CNT = 8'(N_OPERANDS - 1);
  localparam logic [7:0] OE_MASK  = 8'h3C;

  state_t           state_q, state_d;
  logic [SUM_W-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [7:0]       uo_out_q, uo_out_d;
  logic [7:0]       uio_out_q, uio_out_d;
  logic [7:0]       uio_oe_q, uio_oe_d;
  logic             in_valid, out_ack, in_ready, out_valid, accept, xfer;
  logic             busy_d, in_ready_d, out_valid_d, out_hi_d;
  logic             unused;

  assign in_valid  = uio_in[0];
  assign out_ack   = uio_in[1];
  // Handshakes qualify on the registered pin values so the FSM and the far side always agree.
  assign in_ready  = uio_out_q[2];
  assign out_valid = uio_out_q[3];
  assign accept    = in_valid && in_ready;
  assign xfer      = out_valid && out_ack;
  assign unused    = &{ena, uio_in[7:2], 1'b0};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d   = {{(SUM_W-8){1'b0}}, ui_in};
          cnt_d   = 8'd1;
          state_d = (N_OPERANDS == 1) ? SEND_LO : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_d = acc_q + {{(SUM_W-8){1'b0}}, ui_in};
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == LAST_CNT) begin
            state_d = SEND_LO;
          end
        end
      end
      SEND_LO: begin
        if (xfer) begin
          state_d = SEND_HI;
        end
      end
      SEND_HI: begin
        if (xfer) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = 8'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Pin outputs are registered from the next state so they line up with the state register.
  always_comb begin
    busy_d      = 1'b0;
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    out_hi_d    = 1'b0;
    uo_out_d    = uo_out_q;
    unique case (state_d)
      IDLE: begin
        in_ready_d = 1'b1;
      end
      ACCUM: begin
        busy_d     = 1'b1;
        in_ready_d = 1'b1;
      end
      SEND_LO: begin
        busy_d      = 1'b1;
        out_valid_d = 1'b1;
        uo_out_d    = acc_d[7:0];
      end
      SEND_HI: begin
        busy_d      = 1'b1;
        out_valid_d = 1'b1;
        out_hi_d    = 1'b1;
        uo_out_d    = acc_d[SUM_W-1 -: 8];
      end
      default: begin
        in_ready_d = 1'b0;
      end
    endcase
    uio_out_d = {2'b00, busy_d, out_hi_d, out_valid_d, in_ready_d, 2'b00};
    uio_oe_d  = OE_MASK;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= 8'd0;
      uo_out_q  <= 8'd0;
      uio_out_q <= 8'd0;
      uio_oe_q  <= 8'd0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      uo_out_q  <= uo_out_d;
      uio_out_q <= uio_out_d;
      uio_oe_q  <= uio_oe_d;
    end
  end

  assign uo_out  = uo_out_q;
  assign uio_out = uio_out_q;
  assign uio_oe  = uio_oe_q;

endmodule

// File: tb/tb_tt_um_sofiaeg_sum_tx.sv
// tb/tb_tt_um_sofiaeg_sum_tx.sv - scoreboard bench for the sum transmitter (N=2 and N=4 instances)
module tb_tt_um_sofiaeg_sum_tx;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst       [2];
  logic [7:0] ui        [2];
  logic       in_v      [2];
  logic       ack       [2] = '{1'b0, 1'b0};
  logic       ack_force [2];
  logic       ack_rand  [2];
  logic [7:0] uo        [2];
  logic [7:0] uio_o     [2];
  logic [7:0] oe        [2];
  logic [8:0] exp_q     [2][$];
  logic       hold_v    [2] = '{1'b0, 1'b0};
  logic [8:0] hold_d    [2];
  logic [7:0] ops[$];
  int n_chk = 0;
  int n_fail = 0;

  tt_um_sofiaeg_sum_tx #(.N_OPERANDS(2), .SUM_W(16)) dut2 (
    .clk(clk), .rst(rst[0]), .ui_in(ui[0]), .uo_out(uo[0]),
    .uio_in({6'b0, ack[0], in_v[0]}), .uio_out(uio_o[0]), .uio_oe(oe[0]), .ena(1'b1)
  );

  tt_um_sofiaeg_sum_tx #(.N_OPERANDS(4), .SUM_W(16)) dut4 (
    .clk(clk), .rst(rst[1]), .ui_in(ui[1]), .uo_out(uo[1]),
    .uio_in({6'b0, ack[1], in_v[1]}), .uio_out(uio_o[1]), .uio_oe(oe[1]), .ena(1'b1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_op(input int k, input logic [7:0] v);
    int t = 0;
    in_v[k] = 1'b1;
    ui[k]   = v;
    @(negedge clk);
    while (!uio_o[k][2] && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("operand_accept_timeout", 32'(uio_o[k][2]), 32'd1);
    tick();
    in_v[k] = 1'b0;
  endtask

  task automatic drain(input int k);
    int t = 0;
    while (exp_q[k].size() != 0 && t < 300) begin
      tick();
      t++;
    end
    chk("drain_timeout", 32'(exp_q[k].size()), 32'd0);
    exp_q[k].delete();
  endtask

  // Reference: the transmitted pair is the plain arithmetic sum mod 2^16, low byte first.
  task automatic run_txn(input int k, input logic [7:0] o[$], input int mingap, input int maxgap);
    int s = 0;
    foreach (o[i]) s += int'(o[i]);
    s = s % 65536;
    exp_q[k].push_back({1'b0, s[7:0]});
    exp_q[k].push_back({1'b1, s[15:8]});
    foreach (o[i]) begin
      send_op(k, o[i]);
      repeat ($urandom_range(maxgap, mingap)) tick();
    end
    drain(k);
  endtask

  always begin
    @(posedge clk);
    #2;
    for (int k = 0; k < 2; k++) begin
      ack[k] = ack_rand[k] ? 1'($urandom_range(1, 0)) : ack_force[k];
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst[k]) begin
        hold_v[k] = 1'b0;
      end else begin
        chk("pad_bits_zero", 32'(uio_o[k] & 8'hC3), 32'd0);
        if (hold_v[k]) begin
          chk("backpressure_valid_held", 32'(uio_o[k][3]), 32'd1);
          chk("backpressure_data_stable", 32'({uio_o[k][4], uo[k]}), 32'(hold_d[k]));
        end
        if (uio_o[k][3]) begin
          chk("in_ready_low_while_sending", 32'(uio_o[k][2]), 32'd0);
          if (ack[k]) begin
            if (exp_q[k].size() == 0) begin
              n_chk++;
              n_fail++;
              $display("FAIL stale_byte: dut%0d sent 0x%0h with nothing expected at %0t",
                       k, {uio_o[k][4], uo[k]}, $time);
            end else begin
              chk("tx_byte", 32'({uio_o[k][4], uo[k]}), 32'(exp_q[k].pop_front()));
            end
          end
          hold_v[k] = !ack[k];
          hold_d[k] = {uio_o[k][4], uo[k]};
        end else begin
          hold_v[k] = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; ui[k] = 8'h00; in_v[k] = 1'b0;
      ack_force[k] = 1'b0; ack_rand[k] = 1'b0;
    end
    repeat (3) tick();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("reset_uio_oe", 32'(oe[k]), 32'h00);
      chk("reset_uo_out", 32'(uo[k]), 32'h00);
      chk("reset_uio_out", 32'(uio_o[k]), 32'h00);
    end
    tick();
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    tick();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("idle_uio_oe", 32'(oe[k]), 32'h3C);
      chk("idle_uio_out", 32'(uio_o[k]), 32'h04);
      chk("idle_uo_out", 32'(uo[k]), 32'h00);
    end
    tick();

    // Basic pair, cycle by cycle with ack held high
    ack_force[0] = 1'b1;
    exp_q[0].push_back(9'h03B);
    exp_q[0].push_back(9'h100);
    in_v[0] = 1'b1; ui[0] = 8'h2A;
    @(negedge clk); chk("pair_idle_flags", 32'(uio_o[0]), 32'h04);
    tick(); ui[0] = 8'h11;
    @(negedge clk); chk("pair_accum_flags", 32'(uio_o[0]), 32'h24);
    tick(); in_v[0] = 1'b0;
    @(negedge clk);
    chk("pair_send_lo_flags", 32'(uio_o[0]), 32'h28);
    chk("pair_send_lo_byte", 32'(uo[0]), 32'h3B);
    tick();
    @(negedge clk);
    chk("pair_send_hi_flags", 32'(uio_o[0]), 32'h38);
    chk("pair_send_hi_byte", 32'(uo[0]), 32'h00);
    tick();
    @(negedge clk);
    chk("pair_ready_after_hi", 32'(uio_o[0]), 32'h04);
    chk("pair_uo_holds", 32'(uo[0]), 32'h00);
    tick();
    chk("pair_queue_empty", 32'(exp_q[0].size()), 32'd0);

    // Carry into the high byte
    ops = {8'hFF, 8'hFF};
    run_txn(0, ops, 0, 0);

    // Receiver back-pressure with an operand offered during SEND_LO
    ack_force[0] = 1'b0;
    exp_q[0].push_back(9'h046);
    exp_q[0].push_back(9'h100);
    send_op(0, 8'h12);
    send_op(0, 8'h34);
    in_v[0] = 1'b1; ui[0] = 8'h55;
    repeat (5) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(uio_o[0][3]), 32'd1);
      chk("bp_in_ready", 32'(uio_o[0][2]), 32'd0);
      chk("bp_low_byte", 32'(uo[0]), 32'h46);
      tick();
    end
    in_v[0] = 1'b0;
    ack_force[0] = 1'b1;
    drain(0);
    ops = {8'h05, 8'h06};
    run_txn(0, ops, 0, 0);

    // Gapped source on the four-operand instance
    ack_force[1] = 1'b1;
    ops = {8'd10, 8'd20, 8'd30, 8'd40};
    run_txn(1, ops, 1, 3);

    // Reset after the first operand
    send_op(0, 8'h01);
    rst[0] = 1'b1; tick();
    rst[0] = 1'b0; tick();
    ops = {8'h01, 8'h02};
    run_txn(0, ops, 0, 0);

    // Reset while the high byte is pending
    ack_force[0] = 1'b0;
    exp_q[0].push_back(9'h007);
    exp_q[0].push_back(9'h100);
    send_op(0, 8'h03);
    send_op(0, 8'h04);
    ack_force[0] = 1'b1;
    @(negedge clk);
    tick();
    ack_force[0] = 1'b0;
    rst[0] = 1'b1;
    @(negedge clk);
    chk("hi_pending_flags", 32'(uio_o[0]), 32'h38);
    tick();
    exp_q[0].delete();
    @(negedge clk);
    chk("rst_in_hi_uio_out", 32'(uio_o[0]), 32'h00);
    chk("rst_in_hi_uio_oe", 32'(oe[0]), 32'h00);
    chk("rst_in_hi_uo_out", 32'(uo[0]), 32'h00);
    tick();
    rst[0] = 1'b0;
    ack_force[0] = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("after_rst_idle", 32'(uio_o[0]), 32'h04);
    tick();

    // Randomized transactions with random receiver ack
    ack_rand[0] = 1'b1;
    ack_rand[1] = 1'b1;
    for (int n = 0; n < 20; n++) begin
      ops = {};
      repeat (2) ops.push_back(8'($urandom));
      run_txn(0, ops, 0, 2);
    end
    for (int n = 0; n < 15; n++) begin
      ops = {};
      repeat (4) ops.push_back(8'($urandom));
      run_txn(1, ops, 0, 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tt_um_sofiaeg_sum_tx.md
Name: tt_um_sofiaeg_sum_tx

Overview:
- Sequential companion to the team's combinational pin-adder tile, covering the opposite direction of the pin interface.
- The adder tile takes operands in on `ui_in` and `uio_in` with `uio` permanently input.
- This block accepts a burst of operand bytes on `ui_in` under a valid/ready handshake and accumulates them into a 16-bit sum.
- It then transmits the sum outward as two bytes on `uo_out`, using `uio` as a mixed-direction handshake port (valid/ack) toward an external receiver.

Parameters:
- N_OPERANDS, 2, number of operand bytes summed per transaction (legal 1..255).
- SUM_W, 16, accumulator width in bits; transmitted as SUM_W/8 bytes, fixed at 16 in this release.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- ui_in  input  8  operand byte.
- uo_out  output  8  transmitted result byte.
- uio_in  input  8  bit0 = in_valid (operand present), bit1 = out_ack (receiver accepts byte), bits7:2 ignored.
- uio_out  output  8  bit2 = in_ready, bit3 = out_valid, bit4 = out_hi (1 = high byte on uo_out), bit5 = busy; bits 7:6 and 1:0 driven 0.
- uio_oe  output  8  8'b0011_1100 out of reset; 8'h00 while rst is high.
- ena  input  1  ignored.

Behaviour:
- All state updates on the rising edge of clk. rst is sampled on that edge.
- Reset values:
  - State = IDLE, acc = 0, cnt = 0.
  - uo_out = 0, uio_out = 0, uio_oe = 0.
- uio_oe behaviour:
  - Registered; equals 8'h3C from the first cycle after rst deasserts.
  - Forced to 0 on the cycle rst is sampled high.
- Reset mid-transaction: partial sum and count are discarded. No byte is emitted. The next transaction starts fresh.
- Operand handshake: an operand is accepted on a cycle where in_valid && in_ready.
  - in_ready = 1 only in IDLE and ACCUM.
  - in_valid without in_ready is ignored; the source must hold it.
- Output handshake: a byte is transferred on a cycle where out_valid && out_ack.
  - While out_valid = 1, uo_out and out_hi are stable until transfer.
  - out_ack while out_valid = 0 is ignored.
- State IDLE:
  - busy = 0, in_ready = 1, out_valid = 0.
  - On accept: acc <= zero-extended ui_in, cnt <= 1.
  - Next state is ACCUM, or SEND_LO if N_OPERANDS == 1.
- State ACCUM:
  - busy = 1, in_ready = 1.
  - On accept: acc <= acc + ui_in (zero-extended, modulo 2^16), cnt <= cnt + 1.
  - When the accepted operand is the N_OPERANDS-th, next state is SEND_LO.
  - No timeout: ACCUM waits indefinitely for operands.
- State SEND_LO:
  - busy = 1, in_ready = 0, out_valid = 1, out_hi = 0, uo_out = acc[7:0].
  - On transfer, go to SEND_HI.
- State SEND_HI:
  - out_valid = 1, out_hi = 1, uo_out = acc[15:8].
  - On transfer, go to IDLE with acc and cnt cleared.
- Latency:
  - out_valid rises on the cycle after the final operand is accepted.
  - With ack held high, the two bytes transfer on consecutive cycles.
  - in_ready returns high the cycle after the high-byte transfer.
  - With all handshakes held high, one transaction occupies N_OPERANDS + 2 cycles.
- Arithmetic:
  - Unsigned addition. Overflow beyond 16 bits wraps silently.
  - With N_OPERANDS ≤ 257, no wrap is possible (max 257 × 255 = 65535).
- Simultaneous events:
  - in_valid during SEND_* is not accepted.
  - out_ack held continuously is legal.
  - rst has priority over every handshake.
- uo_out holds its last value in IDLE and ACCUM; it is cleared only by rst.

Test Plan:
- Reset, then idle: rst high 3 cycles, then low → uio_oe = 0 during reset and 8'h3C afterward; uo_out = 0; uio_out = 8'h04 (in_ready only).
- Basic pair, N=2: operands 8'h2A, 8'h11 with ack held high → SEND_LO uo_out = 8'h3B (out_hi = 0), then SEND_HI uo_out = 8'h00 (out_hi = 1); in_ready high again the next cycle; total 4 cycles.
- Carry into high byte: operands 8'hFF, 8'hFF → low byte 8'hFE, high byte 8'h01.
- Receiver back-pressure: ack held low 5 cycles in SEND_LO → uo_out stable at the low byte with out_valid = 1 for all 5 cycles. in_valid asserted with 8'h55 during this time is not accepted; in_ready = 0.
- Gapped source with N_OPERANDS=4: operands 10, 20, 30, 40 with in_valid low for 1–3 cycles between them → result 100 (8'h64, 8'h00). Gap cycles change neither acc nor cnt.
- Reset mid-operation: assert rst after the first operand, then run a fresh pair 8'h01, 8'h02 → output 8'h03, 8'h00. No stale byte is emitted. Repeat with rst asserted in SEND_HI: out_valid drops the next cycle and no byte transfers.
